// File: rtl/multicycle_control.sv
// Control FSM for a multicycle CPU: fetch/decode/exec/mem/writeback sequencing and strobe decode.
// Optional retired-instruction counter is built only when RETIRE_COUNT_EN is defined.
module multicycle_control (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic        branch_taken,
    input  logic        imem_rdy,
    input  logic        dmem_rdy,
    output logic        if_req,
    output logic        ir_we,
    output logic        pc_we,
    output logic        pc_src,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        mem_to_reg,
    output logic        rf_we,
    output logic        instr_done,
    output logic        halted,
    output logic [2:0]  state,
    output logic [31:0] retired_cnt
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_RSV5   = 3'd5,
        S_RSV6   = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        C_ALU = 2'b00,
        C_MEM = 2'b01,
        C_BR  = 2'b10,
        C_ILL = 2'b11
    } class_t;

    state_t state_q;
    class_t cls_q;
    logic   store_q;

    // Only the class field and the load/store bit matter to sequencing.
    logic unused_opcode_bits;
    assign unused_opcode_bits = ^opcode[3:1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            cls_q   <= C_ALU;
            store_q <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (imem_rdy)
                        state_q <= S_DECODE;
                end
                S_DECODE: begin
                    cls_q   <= class_t'(opcode[5:4]);
                    store_q <= opcode[0];
                    state_q <= (opcode[5:4] == 2'b11) ? S_HALT : S_EXEC;
                end
                S_EXEC: begin
                    case (cls_q)
                        C_ALU:   state_q <= S_WB;
                        C_MEM:   state_q <= S_MEM;
                        default: state_q <= S_FETCH;
                    endcase
                end
                S_MEM: begin
                    if (dmem_rdy)
                        state_q <= store_q ? S_FETCH : S_WB;
                end
                S_WB:    state_q <= S_FETCH;
                S_HALT:  state_q <= S_HALT;
                default: state_q <= S_FETCH;
            endcase
        end
    end

    // Strobes are gated by rst so memory commands drop the moment reset rises.
    always_comb begin
        if_req     = 1'b0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        pc_src     = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        mem_to_reg = 1'b0;
        rf_we      = 1'b0;
        instr_done = 1'b0;
        halted     = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    if_req = 1'b1;
                    ir_we  = imem_rdy;
                    pc_we  = imem_rdy;
                end
                S_EXEC: begin
                    if (cls_q == C_BR) begin
                        pc_we      = branch_taken;
                        pc_src     = 1'b1;
                        instr_done = 1'b1;
                    end
                end
                S_MEM: begin
                    mem_rd     = !store_q;
                    mem_wr     = store_q;
                    instr_done = store_q && dmem_rdy;
                end
                S_WB: begin
                    rf_we      = 1'b1;
                    mem_to_reg = (cls_q == C_MEM) && !store_q;
                    instr_done = 1'b1;
                end
                S_HALT:  halted = 1'b1;
                default: ;
            endcase
        end
    end

    assign state = state_q;

`ifdef RETIRE_COUNT_EN
    logic [31:0] retire_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            retire_q <= '0;
        else if (instr_done)
            retire_q <= retire_q + 32'd1;
    end

    assign retired_cnt = retire_q;
`else
    assign retired_cnt = '0;
`endif

    a_rd_wr_excl: assert property (@(posedge clk) disable iff (rst) !(mem_rd && mem_wr));
    a_rf_wr_excl: assert property (@(posedge clk) disable iff (rst) !(rf_we && mem_wr));

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-instruction expected traces against the DUT.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opcode;
    logic        branch_taken, imem_rdy, dmem_rdy;
    logic        if_req, ir_we, pc_we, pc_src, mem_rd, mem_wr, mem_to_reg, rf_we, instr_done, halted;
    logic [2:0]  state;
    logic [31:0] retired_cnt;
    logic [9:0]  strobes;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_ret = '0;

    localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_E = 3'd2, S_M = 3'd3, S_W = 3'd4, S_H = 3'd7;

    // One expected cycle: state, strobe vector and the inputs to drive in that cycle.
    typedef struct {
        logic [2:0] st;
        logic [9:0] outs;
        logic       im;
        logic       dm;
        logic       bt;
    } cyc_t;
    cyc_t tr[$];

    multicycle_control dut (
        .clk(clk), .rst(rst), .opcode(opcode), .branch_taken(branch_taken),
        .imem_rdy(imem_rdy), .dmem_rdy(dmem_rdy), .if_req(if_req), .ir_we(ir_we),
        .pc_we(pc_we), .pc_src(pc_src), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_to_reg(mem_to_reg), .rf_we(rf_we), .instr_done(instr_done),
        .halted(halted), .state(state), .retired_cnt(retired_cnt)
    );

    assign strobes = {if_req, ir_we, pc_we, pc_src, mem_rd, mem_wr, mem_to_reg, rf_we, instr_done, halted};

    always #5 clk = ~clk;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic void push(input logic [2:0] st, input logic [9:0] o,
                                 input logic im, input logic dm, input logic bt);
        cyc_t c;
        c.st = st; c.outs = o; c.im = im; c.dm = dm; c.bt = bt;
        tr.push_back(c);
    endfunction

    // Expected cycle sequence of one instruction: iw fetch stalls, dw data-memory stalls.
    function automatic void expand(input logic [5:0] op, input int iw, input int dw, input logic bt);
        logic is_st;
        is_st = op[0];
        for (int i = 0; i < iw; i++) push(S_F, 10'b1000000000, 1'b0, rb(), rb());
        push(S_F, 10'b1110000000, 1'b1, rb(), rb());
        push(S_D, 10'b0000000000, rb(), rb(), rb());
        case (op[5:4])
            2'b10: push(S_E, {2'b00, bt, 1'b1, 4'b0000, 1'b1, 1'b0}, rb(), rb(), bt);
            2'b00: begin
                push(S_E, 10'b0000000000, rb(), rb(), rb());
                push(S_W, 10'b0000000110, rb(), rb(), rb());
            end
            2'b01: begin
                push(S_E, 10'b0000000000, rb(), rb(), rb());
                for (int i = 0; i < dw; i++)
                    push(S_M, is_st ? 10'b0000010000 : 10'b0000100000, rb(), 1'b0, rb());
                push(S_M, is_st ? 10'b0000010010 : 10'b0000100000, rb(), 1'b1, rb());
                if (!is_st) push(S_W, 10'b0000001110, rb(), rb(), rb());
            end
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] bump(input logic [31:0] v);
`ifdef RETIRE_COUNT_EN
        return v + 32'd1;
`else
        return v;
`endif
    endfunction

    task automatic drive(input logic im, input logic dm, input logic bt);
        @(negedge clk);
        imem_rdy = im; dmem_rdy = dm; branch_taken = bt;
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1; opcode = '0; imem_rdy = 1'b1; dmem_rdy = 1'b1; branch_taken = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        checks++; if (state !== S_F) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", state, S_F); end
        checks++; if (strobes !== 10'b0) begin failures++; $display("FAIL reset_strobes got=%b exp=%b", strobes, 10'b0); end
        checks++; if (retired_cnt !== 32'd0) begin failures++; $display("FAIL reset_cnt got=%0h exp=0", retired_cnt); end
        @(posedge clk); #1 rst = 1'b0;
        exp_ret = '0;
    endtask

    task automatic test_fixed(input string nm, input logic [5:0] op, input int iw, input int dw, input logic bt);
        tr.delete(); opcode = op; expand(op, iw, dw, bt);
        foreach (tr[i]) begin
            drive(tr[i].im, tr[i].dm, tr[i].bt);
            checks++; if (state !== tr[i].st) begin failures++; $display("FAIL %s_state cyc=%0d got=%0d exp=%0d", nm, i, state, tr[i].st); end
            checks++; if (strobes !== tr[i].outs) begin failures++; $display("FAIL %s_strobes cyc=%0d got=%b exp=%b", nm, i, strobes, tr[i].outs); end
            checks++; if (retired_cnt !== exp_ret) begin failures++; $display("FAIL %s_cnt cyc=%0d got=%0h exp=%0h", nm, i, retired_cnt, exp_ret); end
            if (tr[i].outs[1]) exp_ret = bump(exp_ret);
        end
    endtask

    task automatic test_random();
        logic [5:0] op;
        for (int n = 0; n < 40; n++) begin
            op = 6'($urandom);
            op[5:4] = 2'($urandom_range(0, 2));
            tr.delete(); opcode = op;
            expand(op, $urandom_range(0, 2), $urandom_range(0, 3), rb());
            foreach (tr[i]) begin
                drive(tr[i].im, tr[i].dm, tr[i].bt);
                checks++; if (state !== tr[i].st) begin failures++; $display("FAIL rand_state op=%b cyc=%0d got=%0d exp=%0d", op, i, state, tr[i].st); end
                checks++; if (strobes !== tr[i].outs) begin failures++; $display("FAIL rand_strobes op=%b cyc=%0d got=%b exp=%b", op, i, strobes, tr[i].outs); end
                checks++; if (retired_cnt !== exp_ret) begin failures++; $display("FAIL rand_cnt op=%b cyc=%0d got=%0h exp=%0h", op, i, retired_cnt, exp_ret); end
                if (tr[i].outs[1]) exp_ret = bump(exp_ret);
            end
        end
    endtask

    task automatic test_wrap();
`ifdef RETIRE_COUNT_EN
        @(posedge clk); #1;
        force dut.retire_q = 32'hFFFF_FFFF;
        #1 release dut.retire_q;
        exp_ret = 32'hFFFF_FFFF;
`endif
        test_fixed("wrap", 6'b000000, 0, 0, 1'b0);
        @(posedge clk); #1;
        checks++; if (retired_cnt !== 32'd0) begin failures++; $display("FAIL wrap_final got=%0h exp=0", retired_cnt); end
    endtask

    task automatic test_async_reset();
        tr.delete(); opcode = 6'b010001; expand(opcode, 0, 10, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(tr[i].im, tr[i].dm, tr[i].bt);
            checks++; if (strobes !== tr[i].outs) begin failures++; $display("FAIL arst_pre cyc=%0d got=%b exp=%b", i, strobes, tr[i].outs); end
        end
        #1 rst = 1'b1;
        #1;
        checks++; if (mem_wr !== 1'b0) begin failures++; $display("FAIL arst_memwr got=%b exp=0", mem_wr); end
        checks++; if (state !== S_F) begin failures++; $display("FAIL arst_state got=%0d exp=%0d", state, S_F); end
        checks++; if (retired_cnt !== 32'd0) begin failures++; $display("FAIL arst_cnt got=%0h exp=0", retired_cnt); end
        exp_ret = '0;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_halt();
        test_fixed("halt_pre", 6'b110000, 0, 0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, rb(), rb());
            checks++; if (state !== S_H) begin failures++; $display("FAIL halt_state cyc=%0d got=%0d exp=%0d", i, state, S_H); end
            checks++; if (strobes !== 10'b0000000001) begin failures++; $display("FAIL halt_strobes cyc=%0d got=%b exp=%b", i, strobes, 10'b0000000001); end
        end
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        exp_ret = '0;
        drive(1'b0, 1'b0, 1'b0);
        checks++; if (state !== S_F) begin failures++; $display("FAIL halt_exit_state got=%0d exp=%0d", state, S_F); end
        checks++; if (strobes !== 10'b1000000000) begin failures++; $display("FAIL halt_exit_strobes got=%b exp=%b", strobes, 10'b1000000000); end
    endtask

    initial begin
        test_reset();
        test_fixed("alu", 6'b000000, 0, 0, 1'b0);
        test_fixed("load_wait", 6'b010000, 1, 3, 1'b0);
        test_fixed("store", 6'b010001, 0, 0, 1'b0);
        test_fixed("br_taken", 6'b100000, 0, 0, 1'b1);
        test_fixed("br_not", 6'b100000, 2, 0, 1'b0);
        test_random();
        test_wrap();
        test_async_reset();
        test_halt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout reached without completing");
        $fatal(1);
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have port: clk  in  1  single clock, all state updates on rising edge.
REQ-002 SHALL have port: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have port: opcode  in  6  instruction opcode from IR, valid from DECODE onward.
REQ-004 SHALL have port: branch_taken  in  1  branch condition result from branch unit, sampled in EXEC.
REQ-005 SHALL have port: imem_rdy  in  1  instruction memory data valid.
REQ-006 SHALL have port: dmem_rdy  in  1  data memory access complete.
REQ-007 SHALL have ports (out, 1 bit each): if_req (fetch request), ir_we (IR load), pc_we (PC load), pc_src (0 = PC+4, 1 = branch target), mem_rd, mem_wr, mem_to_reg, rf_we, instr_done (retire pulse), halted.
REQ-008 SHALL have port: state  out  3  current state encoding.
REQ-009 SHALL have port: retired_cnt  out  32  retired-instruction count (see Configuration).

Function
REQ-010 SHALL be a Moore/Mealy FSM with state encoding FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7; codes 5 and 6 SHALL go to FETCH next cycle.
REQ-011 Opcode classes SHALL be: opcode[5:4]=00 ALU; 01 memory (opcode[0]=0 load, 1 store); 10 branch; 11 illegal.
REQ-012 FETCH: if_req=1; on imem_rdy=1, ir_we=1, pc_we=1, pc_src=0 in that same cycle; next DECODE; otherwise remain in FETCH with ir_we=pc_we=0.
REQ-013 DECODE: one cycle; opcode class SHALL be latched internally; illegal class -> HALT, else -> EXEC.
REQ-014 EXEC: one cycle; ALU -> WB; memory -> MEM; branch: pc_we=branch_taken, pc_src=1, instr_done=1, next FETCH.
REQ-015 MEM: load holds mem_rd=1, store holds mem_wr=1 until dmem_rdy=1; on dmem_rdy, load -> WB, store -> FETCH with instr_done=1 that cycle.
REQ-016 WB: rf_we=1 for one cycle, mem_to_reg=1 only for load, instr_done=1; next FETCH.
REQ-017 HALT: all strobes 0, halted=1; SHALL remain until rst.
REQ-018 Latency with ready inputs high at first request: branch 3 cycles, ALU 4, store 4, load 5.
REQ-019 imem_rdy outside FETCH and dmem_rdy outside MEM SHALL be ignored.
REQ-020 mem_rd and mem_wr SHALL never be asserted together; rf_we and mem_wr SHALL never be asserted together.
REQ-021 All strobe outputs SHALL be decoded from state and latched class only (plus imem_rdy/dmem_rdy/branch_taken where stated), glitch-free relative to clk.

Reset
REQ-022 While rst=1: state=FETCH, all 1-bit outputs 0 except none, retired_cnt=0, latched class=ALU.
REQ-023 rst asserted mid-operation (e.g., in MEM) SHALL deassert mem_rd/mem_wr immediately, without waiting for clk.
REQ-024 First cycle after rst release SHALL be FETCH with if_req=1.

Configuration
REQ-025 Macro RETIRE_COUNT_EN defined: retired_cnt SHALL increment by 1 on each clk edge where instr_done=1, wrapping 0xFFFFFFFF -> 0x00000000.
REQ-026 RETIRE_COUNT_EN undefined: retired_cnt SHALL be constant 0 and no counter register SHALL be synthesized; all other behaviour identical.

Verification
REQ-027 rst=1 then released, imem_rdy=1, opcode=000000 -> states 0,1,2,4,0; rf_we=1 only in WB; instr_done one pulse; retired_cnt=1 (macro on).
REQ-028 opcode=010000, dmem_rdy held 0 for 3 MEM cycles then 1 -> mem_rd=1 for 4 cycles, then WB with rf_we=1, mem_to_reg=1.
REQ-029 opcode=100000, branch_taken=1 -> EXEC asserts pc_we=1, pc_src=1, instr_done=1; branch_taken=0 -> pc_we=0, instr_done=1.
REQ-030 opcode=110000 -> HALT after DECODE, halted=1 for 20 cycles despite imem_rdy=1; rst returns to FETCH.
REQ-031 opcode=010001 in MEM, rst pulsed between edges -> mem_wr falls with rst, state=0, retired_cnt=0.
REQ-032 Macro on, counter preloaded by forcing to 0xFFFFFFFF, one ALU instruction -> retired_cnt=0x00000000; macro off -> retired_cnt=0 throughout.
